// File: rtl/second_dif_ctrl_pkg.sv
// Shared constants and types for the second-difference engine sequencer.
// Holds the default widths, the one-hot state encoding and the signed result type.
package second_dif_ctrl_pkg;

    localparam int unsigned DwDefault      = 12;
    localparam int unsigned WarmupDefault  = 2;
    localparam int unsigned TimeoutDefault = 8;
    localparam int unsigned CntwDefault    = 8;

    typedef logic [3:0] state_t;

    localparam state_t StIdle    = 4'b0001;
    localparam state_t StIssue   = 4'b0010;
    localparam state_t StWaitFin = 4'b0100;
    localparam state_t StOutput  = 4'b1000;

    typedef logic signed [DwDefault:0] result_t;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/second_dif_ctrl_if.sv
// Sample strobe, engine start/finish and result stream between the sequencer and its
// neighbours; master is the sequencer side, slave the surrounding logic.
interface second_dif_ctrl_if
    import second_dif_ctrl_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) ();

    logic                 smp_valid;
    logic [DW-1:0]        smp_data;
    logic                 en_dif;
    logic [DW-1:0]        dif_operand;
    logic signed [DW:0]   dif_result;
    logic                 dif_finish;
    logic                 out_valid;
    logic signed [DW:0]   out_data;
    logic                 out_ready;

    modport master (
        input  smp_valid,
        input  smp_data,
        input  dif_result,
        input  dif_finish,
        input  out_ready,
        output en_dif,
        output dif_operand,
        output out_valid,
        output out_data
    );

    modport slave (
        output smp_valid,
        output smp_data,
        output dif_result,
        output dif_finish,
        output out_ready,
        input  en_dif,
        input  dif_operand,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/second_dif_ctrl_smp_buf1.sv
// One-entry sample buffer with overrun detection and a saturating drop counter.
// A load into a full buffer that is not drained the same cycle drops the new sample.
module second_dif_ctrl_smp_buf1
    import second_dif_ctrl_pkg::*;
#(
    parameter int unsigned DW   = DwDefault,
    parameter int unsigned CNTW = CntwDefault
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [DW-1:0]   load_data,
    input  logic            consume,
    input  logic            flush,
    input  logic            clear,
    output logic            full,
    output logic [DW-1:0]   data,
    output logic            overrun,
    output logic [CNTW-1:0] drop_cnt
);

    logic            full_q, full_d;
    logic [DW-1:0]   data_q, data_d;
    logic            overrun_q, overrun_d;
    logic [CNTW-1:0] drop_q, drop_d;
    logic            drop;

    assign drop = load && full_q && !consume;

    always_comb begin
        full_d    = full_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;

        if (consume) begin
            full_d = 1'b0;
        end
        if (load && !drop) begin
            full_d = 1'b1;
            data_d = load_data;
        end
        if (flush) begin
            full_d = 1'b0;
        end

        if (clear) begin
            overrun_d = 1'b0;
            drop_d    = '0;
        end
        // A fresh drop outranks a same-cycle clear so the event is never lost.
        if (drop) begin
            overrun_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    assign full     = full_q;
    assign data     = data_q;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_q;

endmodule

// File: rtl/second_dif_ctrl.sv
// Sequencer for the shared second-difference engine: buffers samples, issues one engine op
// per sample, discards warm-up results and streams the rest out over valid/ready.
module second_dif_ctrl
    import second_dif_ctrl_pkg::*;
#(
    parameter int unsigned DW      = DwDefault,
    parameter int unsigned WARMUP  = WarmupDefault,
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter int unsigned CNTW    = CntwDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    second_dif_ctrl_if.master bus,
    output logic              overrun,
    output logic [CNTW-1:0]   drop_cnt,
    output logic              timeout_err,
    output logic              busy
);

    localparam int unsigned WarmW = cnt_width(WARMUP);
    localparam int unsigned TmoW  = cnt_width(TIMEOUT);

    state_t             state_q, state_d;
    logic               run_q;
    logic               run_rise;
    logic [WarmW-1:0]   warm_q, warm_d;
    logic [TmoW-1:0]    tcnt_q, tcnt_d;
    logic [DW-1:0]      operand_q, operand_d;
    logic signed [DW:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               timeout_q, timeout_d;

    logic               buf_load;
    logic               buf_full;
    logic [DW-1:0]      buf_data;
    logic               start;

    assign run_rise = run && !run_q;
    assign buf_load = bus.smp_valid && run;
    // Operand is latched on the way into ISSUE so it is already valid alongside en_dif.
    assign start    = (state_q == StIdle) && run && buf_full;

    second_dif_ctrl_smp_buf1 #(
        .DW   (DW),
        .CNTW (CNTW)
    ) u_smp_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .load_data (bus.smp_data),
        .consume   (start),
        .flush     (!run),
        .clear     (run_rise),
        .full      (buf_full),
        .data      (buf_data),
        .overrun   (overrun),
        .drop_cnt  (drop_cnt)
    );

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        tcnt_d      = tcnt_q;
        operand_d   = operand_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        timeout_d   = timeout_q;

        if (run_rise) begin
            warm_d    = WarmW'(WARMUP);
            timeout_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    operand_d = buf_data;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                tcnt_d  = TmoW'(1);
                state_d = StWaitFin;
            end
            StWaitFin: begin
                if (bus.dif_finish) begin
                    if (warm_q != '0) begin
                        if (!run_rise) begin
                            warm_d = warm_q - 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        out_data_d  = bus.dif_result;
                        out_valid_d = 1'b1;
                        state_d     = StOutput;
                    end
                end else if (tcnt_q >= TmoW'(TIMEOUT - 1)) begin
                    // Flag becomes visible exactly TIMEOUT cycles after the en_dif cycle.
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StOutput: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            run_q       <= 1'b0;
            warm_q      <= WarmW'(WARMUP);
            tcnt_q      <= '0;
            operand_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run;
            warm_q      <= warm_d;
            tcnt_q      <= tcnt_d;
            operand_q   <= operand_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.en_dif      = (state_q == StIssue);
    assign bus.dif_operand = operand_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign timeout_err     = timeout_q;
    assign busy            = (state_q != StIdle);

    state_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot(state_q));

    out_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_data));

endmodule

// File: tb/tb_second_dif_ctrl.sv
// Bench for second_dif_ctrl with a behavioural second-difference engine stub, a table of
// directed vectors, randomized samples against a reference model and multi-cycle corner cases.
module tb_second_dif_ctrl;
    import second_dif_ctrl_pkg::*;

    localparam int unsigned DW      = 12;
    localparam int unsigned WARMUP  = 2;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNTW    = 8;

    typedef logic signed [DW:0] res_t;

    typedef struct {
        bit            restart;
        logic [DW-1:0] smp;
        bit            has_res;
        int            exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run = 1'b0;
    logic            overrun;
    logic [CNTW-1:0] drop_cnt;
    logic            timeout_err;
    logic            busy;

    int errors = 0;
    int checks = 0;

    second_dif_ctrl_if #(.DW(DW)) bus ();

    second_dif_ctrl #(
        .DW      (DW),
        .WARMUP  (WARMUP),
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .bus         (bus),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Engine stub: finish two cycles after en_dif; result = x[n] - 2x[n-1] + x[n-2] in 13 bits.
    logic          eng_stall = 1'b0;
    logic [DW-1:0] eng_h1, eng_h2;
    logic [1:0]    eng_fin;
    res_t          eng_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_h1  <= '0;
            eng_h2  <= '0;
            eng_fin <= '0;
            eng_res <= '0;
        end else begin
            eng_fin <= {eng_fin[0], bus.en_dif && !eng_stall};
            if (bus.en_dif && !eng_stall) begin
                eng_res <= res_t'(int'(bus.dif_operand) - 2 * int'(eng_h1) + int'(eng_h2));
                eng_h2  <= eng_h1;
                eng_h1  <= bus.dif_operand;
            end
        end
    end

    assign bus.dif_finish = eng_fin[1];
    assign bus.dif_result = eng_res;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: results are second differences of the samples accepted since the
    // latest run rise (or reset), with the first WARMUP of them withheld.
    res_t          exp_q[$];
    logic [DW-1:0] m_p1 = '0;
    logic [DW-1:0] m_p2 = '0;
    int            m_n = 0;

    task automatic model_rise();
        m_n = 0;
    endtask

    task automatic model_sample(input logic [DW-1:0] s);
        m_n++;
        if (m_n > WARMUP) exp_q.push_back(res_t'(int'(s) - 2 * int'(m_p1) + int'(m_p2)));
        m_p2 = m_p1;
        m_p1 = s;
    endtask

    // Output monitor: every handshake must match the next expected result, and a stalled
    // beat must keep out_valid high with unchanged data.
    bit   mon_en = 1'b0;
    logic stall_prev = 1'b0;
    res_t data_prev = '0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (stall_prev) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, data_prev);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_out: got %0d expected no result", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
            stall_prev <= bus.out_valid && !bus.out_ready;
            data_prev  <= bus.out_data;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [DW-1:0] s);
        bus.smp_data  = s;
        bus.smp_valid = 1'b1;
        step();
        bus.smp_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit rnd);
        int n = 0;
        step(2);
        while ((busy || bus.out_valid) && n < 200) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        bus.out_ready = 1'b1;
        check(name, (n < 200) ? 1 : 0, 1);
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (!bus.en_dif && n < 20) begin
            step();
            n++;
        end
        check(name, bus.en_dif, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_en_dif"}, bus.en_dif, 0);
        check({tag, "_operand"}, bus.dif_operand, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_timeout"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[9];
        logic [DW-1:0] s;
        int            n;

        // The 13-bit result wraps, so +-8190 appear as -2 / +2 on out_data.
        tbl[0] = '{1'b1, 12'd100,  1'b0, 0};
        tbl[1] = '{1'b0, 12'd110,  1'b0, 0};
        tbl[2] = '{1'b0, 12'd130,  1'b1, 10};
        tbl[3] = '{1'b0, 12'd160,  1'b1, 10};
        tbl[4] = '{1'b1, 12'd0,    1'b0, 0};
        tbl[5] = '{1'b0, 12'd4095, 1'b0, 0};
        tbl[6] = '{1'b0, 12'd0,    1'b1, -8190};
        tbl[7] = '{1'b0, 12'd4095, 1'b1, 8190};
        tbl[8] = '{1'b0, 12'd0,    1'b1, -8190};

        bus.smp_valid = 1'b0;
        bus.smp_data  = '0;
        bus.out_ready = 1'b1;

        #12;
        check_reset_vals("rst");
        step();
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;

        // Directed vectors: ramp and full-scale alternation, each after a run restart.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].restart) begin
                run = 1'b0;
                step(2);
                run = 1'b1;
                step(2);
            end
            if (tbl[i].has_res) exp_q.push_back(res_t'(tbl[i].exp));
            pulse(tbl[i].smp);
            wait_idle("tbl_idle", 1'b0);
            check("tbl_drain", exp_q.size(), 0);
        end
        check("tbl_overrun", overrun, 0);
        check("tbl_drop_cnt", drop_cnt, 0);

        // Randomized samples with random back-pressure and occasional run restarts.
        run = 1'b0;
        step(2);
        run = 1'b1;
        model_rise();
        step(2);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                run = 1'b0;
                step($urandom_range(1, 3));
                run = 1'b1;
                model_rise();
                step(2);
            end
            step($urandom_range(1, 5));
            case ($urandom_range(0, 3))
                0:       s = '0;
                1:       s = '1;
                default: s = DW'($urandom_range(0, 4095));
            endcase
            model_sample(s);
            pulse(s);
            wait_idle("rnd_idle", 1'b1);
            check("rnd_drain", exp_q.size(), 0);
        end
        check("rnd_overrun", overrun, 0);
        check("rnd_drop_cnt", drop_cnt, 0);
        check("rnd_timeout", timeout_err, 0);

        // Back-pressure: result held, a third sample overruns the one-entry buffer.
        mon_en = 1'b0;
        rst_n  = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        model_rise();
        step();
        mon_en = 1'b1;
        model_sample(12'd1000);
        pulse(12'd1000);
        wait_idle("bp_warm0", 1'b0);
        model_sample(12'd1200);
        pulse(12'd1200);
        wait_idle("bp_warm1", 1'b0);
        bus.out_ready = 1'b0;
        model_sample(12'd3000);
        pulse(12'd3000);
        step(4);
        model_sample(12'd50);
        pulse(12'd50);
        step(4);
        pulse(12'd4000);
        step(10);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_overrun", overrun, 1);
        check("bp_drop_cnt", drop_cnt, 1);
        bus.out_ready = 1'b1;
        wait_idle("bp_idle", 1'b0);
        check("bp_drain", exp_q.size(), 0);
        check("bp_drop_keep", drop_cnt, 1);

        // Engine that never finishes: timeout exactly TIMEOUT cycles after en_dif.
        eng_stall = 1'b1;
        pulse(12'd777);
        wait_en("tmo_en_seen");
        step(TIMEOUT - 1);
        check("tmo_early", timeout_err, 0);
        step();
        check("tmo_err", timeout_err, 1);
        check("tmo_idle", busy, 0);
        eng_stall = 1'b0;

        // run dropped mid WAIT_FIN: result still delivered; re-raise clears flags and warm-up.
        model_sample(12'd2500);
        pulse(12'd2500);
        wait_en("fall_en_seen");
        step();
        run = 1'b0;
        wait_idle("fall_idle", 1'b0);
        check("fall_drain", exp_q.size(), 0);
        check("fall_tmo_keep", timeout_err, 1);
        check("fall_ovr_keep", overrun, 1);
        run = 1'b1;
        model_rise();
        step(2);
        check("rise_overrun", overrun, 0);
        check("rise_drop_cnt", drop_cnt, 0);
        check("rise_timeout", timeout_err, 0);
        for (int i = 0; i < 3; i++) begin
            s = DW'($urandom_range(0, 4095));
            model_sample(s);
            pulse(s);
            wait_idle("rise_idle", 1'b0);
            check("rise_drain", exp_q.size(), 0);
        end

        // Asynchronous reset while a result waits in OUTPUT.
        bus.out_ready = 1'b0;
        model_sample(12'd321);
        pulse(12'd321);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check("ar_out_valid", bus.out_valid, 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("ar");
        exp_q.delete();
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
